// File: rtl/spi_ss_master.sv
// ---------------------------------------------------------------------------
// spi_ss_master : SPI mode-0 master with framed slave-select and Tx enable
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_ss_master #(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int SS_LEAD_CLKS      = 2,
    parameter int SS_TRAIL_CLKS     = 2,
    parameter int SS_IDLE_CLKS      = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_Last,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_SPI_Clk,
    output logic       o_SPI_MOSI,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_SS,
    output logic       o_Tx_On
);

    localparam int c_HALF_W  = $clog2(CLKS_PER_HALF_BIT + 1);
    localparam int c_DLY_MAX = (SS_LEAD_CLKS > SS_TRAIL_CLKS) ?
                               ((SS_LEAD_CLKS > SS_IDLE_CLKS) ? SS_LEAD_CLKS : SS_IDLE_CLKS) :
                               ((SS_TRAIL_CLKS > SS_IDLE_CLKS) ? SS_TRAIL_CLKS : SS_IDLE_CLKS);
    localparam int c_DLY_W   = $clog2(c_DLY_MAX + 1);

    localparam logic [c_HALF_W-1:0] c_HALF_LAST  = c_HALF_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [c_DLY_W-1:0]  c_LEAD_LAST  = c_DLY_W'(SS_LEAD_CLKS - 1);
    localparam logic [c_DLY_W-1:0]  c_TRAIL_LAST = c_DLY_W'(SS_TRAIL_CLKS - 1);
    localparam logic [c_DLY_W-1:0]  c_IDLE_LAST  = c_DLY_W'(SS_IDLE_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LEAD     = 3'd1,
        S_SHIFT    = 3'd2,
        S_HOLD_LOW = 3'd3,
        S_TRAIL    = 3'd4,
        S_SS_IDLE  = 3'd5
    } state_t;

    state_t              r_state;
    logic [7:0]          r_tx_byte;
    logic                r_tx_last;
    logic [7:0]          r_rx_shift;
    logic [2:0]          r_bit_cnt;
    logic [c_HALF_W-1:0] r_half_cnt;
    logic [c_DLY_W-1:0]  r_dly_cnt;

    logic                r_TX_Ready;
    logic [7:0]          r_RX_Byte;
    logic                r_RX_DV;
    logic                r_SPI_Clk;
    logic                r_SPI_MOSI;
    logic                r_SPI_SS;
    logic                r_Tx_On;

    logic                w_accept;

    // Ready is only ever high in IDLE and HOLD_LOW, so it alone gates acceptance.
    assign w_accept = i_TX_DV & r_TX_Ready;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state    <= S_IDLE;
            r_tx_byte  <= 8'd0;
            r_tx_last  <= 1'b0;
            r_rx_shift <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_half_cnt <= '0;
            r_dly_cnt  <= '0;
            r_TX_Ready <= 1'b1;
            r_RX_Byte  <= 8'd0;
            r_RX_DV    <= 1'b0;
            r_SPI_Clk  <= 1'b0;
            r_SPI_MOSI <= 1'b0;
            r_SPI_SS   <= 1'b1;
            r_Tx_On    <= 1'b0;
        end else begin
            r_RX_DV <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tx_byte  <= i_TX_Byte;
                        r_tx_last  <= i_TX_Last;
                        r_TX_Ready <= 1'b0;
                        r_SPI_SS   <= 1'b0;
                        r_Tx_On    <= 1'b1;
                        r_SPI_MOSI <= i_TX_Byte[7];
                        r_dly_cnt  <= '0;
                        r_state    <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (r_dly_cnt == c_LEAD_LAST) begin
                        r_dly_cnt  <= '0;
                        r_half_cnt <= '0;
                        r_bit_cnt  <= 3'd7;
                        r_state    <= S_SHIFT;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_half_cnt == c_HALF_LAST) begin
                        r_half_cnt <= '0;
                        if (!r_SPI_Clk) begin
                            // Rising edge: capture MISO, MSB arrives first.
                            r_SPI_Clk  <= 1'b1;
                            r_rx_shift <= {r_rx_shift[6:0], i_SPI_MISO};
                        end else begin
                            r_SPI_Clk <= 1'b0;
                            if (r_bit_cnt == 3'd0) begin
                                r_RX_Byte <= r_rx_shift;
                                r_RX_DV   <= 1'b1;
                                if (r_tx_last) begin
                                    r_dly_cnt <= '0;
                                    r_state   <= S_TRAIL;
                                end else begin
                                    r_TX_Ready <= 1'b1;
                                    r_state    <= S_HOLD_LOW;
                                end
                            end else begin
                                r_bit_cnt  <= r_bit_cnt - 3'd1;
                                r_SPI_MOSI <= r_tx_byte[r_bit_cnt - 3'd1];
                            end
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + 1'b1;
                    end
                end
                S_HOLD_LOW: begin
                    // Frame stays open; the next byte skips the lead-in delay.
                    if (w_accept) begin
                        r_tx_byte  <= i_TX_Byte;
                        r_tx_last  <= i_TX_Last;
                        r_TX_Ready <= 1'b0;
                        r_SPI_MOSI <= i_TX_Byte[7];
                        r_half_cnt <= '0;
                        r_bit_cnt  <= 3'd7;
                        r_state    <= S_SHIFT;
                    end
                end
                S_TRAIL: begin
                    if (r_dly_cnt == c_TRAIL_LAST) begin
                        r_SPI_SS  <= 1'b1;
                        r_Tx_On   <= 1'b0;
                        r_dly_cnt <= '0;
                        r_state   <= S_SS_IDLE;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                    end
                end
                S_SS_IDLE: begin
                    if (r_dly_cnt == c_IDLE_LAST) begin
                        r_dly_cnt  <= '0;
                        r_TX_Ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_TX_Ready = r_TX_Ready;
    assign o_RX_Byte  = r_RX_Byte;
    assign o_RX_DV    = r_RX_DV;
    assign o_SPI_Clk  = r_SPI_Clk;
    assign o_SPI_MOSI = r_SPI_MOSI;
    assign o_SPI_SS   = r_SPI_SS;
    assign o_Tx_On    = r_Tx_On;

endmodule

`default_nettype wire

// File: tb/tb_spi_ss_master.sv
// ---------------------------------------------------------------------------
// tb_spi_ss_master : directed self-checking bench for spi_ss_master
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_ss_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    // Default-parameter instance
    logic [7:0] tx_byte = 8'd0;
    logic       tx_last = 1'b0;
    logic       tx_dv = 1'b0;
    logic       ready;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ss;
    logic       txon;
    logic       loop_en = 1'b1;
    logic       miso_val = 1'b0;

    // CLKS_PER_HALF_BIT = 1 instance
    logic [7:0] tx1_byte = 8'd0;
    logic       tx1_last = 1'b0;
    logic       tx1_dv = 1'b0;
    logic       ready1;
    logic [7:0] rx1_byte;
    logic       rx1_dv;
    logic       sclk1;
    logic       mosi1;
    logic       ss1;
    logic       txon1;

    int n_checks = 0;
    int n_errors = 0;

    assign miso = loop_en ? mosi : miso_val;

    always #5 clk = ~clk;

    spi_ss_master dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_TX_Byte  (tx_byte),
        .i_TX_Last  (tx_last),
        .i_TX_DV    (tx_dv),
        .o_TX_Ready (ready),
        .o_RX_Byte  (rx_byte),
        .o_RX_DV    (rx_dv),
        .o_SPI_Clk  (sclk),
        .o_SPI_MOSI (mosi),
        .i_SPI_MISO (miso),
        .o_SPI_SS   (ss),
        .o_Tx_On    (txon)
    );

    spi_ss_master #(.CLKS_PER_HALF_BIT(1)) dut1 (
        .i_Clk      (clk),
        .i_Rst_L    (rst_n),
        .i_TX_Byte  (tx1_byte),
        .i_TX_Last  (tx1_last),
        .i_TX_DV    (tx1_dv),
        .o_TX_Ready (ready1),
        .o_RX_Byte  (rx1_byte),
        .o_RX_DV    (rx1_dv),
        .o_SPI_Clk  (sclk1),
        .o_SPI_MOSI (mosi1),
        .i_SPI_MISO (mosi1),
        .o_SPI_SS   (ss1),
        .o_Tx_On    (txon1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One last=1 frame on the default instance, accepted in the current cycle (cycle 0).
    // Returns in cycle 41 with Ready high.
    task automatic single_frame(input logic [7:0] tx, input logic [7:0] exp_rx,
                                input logic chk_mosi, input int p1, input int p2);
        int   rises;
        int   dvs;
        int   ss_hi;
        logic prev;
        rises = 0; dvs = 0; ss_hi = 0; prev = 1'b0;
        tx_byte = tx; tx_last = 1'b1; tx_dv = 1'b1;
        tick();
        for (int c = 1; c <= 41; c++) begin
            tx_dv = (c == p1) || (c == p2);
            if (sclk && !prev) begin
                if (chk_mosi) chk("mosi_at_rise", mosi, tx[7-rises]);
                rises++;
            end
            prev = sclk;
            if (rx_dv) dvs++;
            if (ss) ss_hi++;
            if (c == 1)  begin chk("ss_low_c1", ss, 0); chk("txon_c1", txon, 1); end
            if (c == 2)  chk("ready_low_c2", ready, 0);
            if (c == 4)  chk("sclk_low_c4", sclk, 0);
            if (c == 5)  chk("sclk_rise_c5", sclk, 1);
            if (c == 35) begin chk("rx_dv_c35", rx_dv, 1); chk("rx_byte_c35", rx_byte, exp_rx); end
            if (c == 36) chk("ss_trail_c36", ss, 0);
            if (c == 37) begin chk("ss_high_c37", ss, 1); chk("txon_off_c37", txon, 0); end
            if (c == 40) chk("ready_low_c40", ready, 0);
            if (c == 41) chk("ready_high_c41", ready, 1);
            if (c < 41) tick();
        end
        tx_dv = 1'b0;
        chk("sclk_rises", rises, 8);
        chk("rx_dv_count", dvs, 1);
        chk("ss_high_cycles", ss_hi, 5);
    endtask

    initial begin
        int   rises;
        int   dvs;
        logic ss_ok;
        logic prev;
        logic [15:0] pat;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ss", ss, 1);
        chk("rst_txon", txon, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx_byte", rx_byte, 0);
        chk("rst_rx_dv", rx_dv, 0);
        chk("rst_ready", ready, 1);
        tick(); tick();
        #3 rst_n = 1'b1;
        tick();

        // Single byte 0xA5, loopback
        loop_en = 1'b1;
        single_frame(8'hA5, 8'hA5, 1'b1, 0, 0);

        // Two-byte frame: 0x3C (open) then 0xC3 (last)
        rises = 0; dvs = 0; ss_ok = 1'b1; prev = 1'b0; pat = 16'h3CC3;
        tx_byte = 8'h3C; tx_last = 1'b0; tx_dv = 1'b1;
        tick();
        tx_dv = 1'b0;
        for (int c = 1; c <= 74; c++) begin
            if (sclk && !prev) begin
                chk("mosi2_at_rise", mosi, pat[15-rises]);
                rises++;
            end
            prev = sclk;
            if (rx_dv) dvs++;
            if (c <= 69 && ss) ss_ok = 1'b0;
            if (c == 35) begin
                chk("rx_dv_3c", rx_dv, 1);
                chk("rx_byte_3c", rx_byte, 8'h3C);
                chk("hold_ready_c35", ready, 1);
                tx_byte = 8'hC3; tx_last = 1'b1; tx_dv = 1'b1;
            end
            if (c == 36) begin
                tx_dv = 1'b0;
                chk("ready_low_c36", ready, 0);
                chk("sclk_low_c36", sclk, 0);
            end
            if (c == 38) chk("no_lead_rise_c38", sclk, 1);
            if (c == 68) begin chk("rx_dv_c3", rx_dv, 1); chk("rx_byte_c3", rx_byte, 8'hC3); end
            if (c == 70) chk("ss_high_c70", ss, 1);
            if (c == 74) chk("ready_c74", ready, 1);
            if (c < 74) tick();
        end
        chk("ss_low_across_frame", ss_ok, 1);
        chk("two_byte_rises", rises, 16);
        chk("two_byte_dv_count", dvs, 2);

        // MISO tied high / low
        loop_en = 1'b0; miso_val = 1'b1;
        single_frame(8'h00, 8'hFF, 1'b1, 0, 0);
        miso_val = 1'b0;
        single_frame(8'hFF, 8'h00, 1'b1, 0, 0);

        // Ignored TX_DV during SHIFT and SS_IDLE, then back-to-back frame
        loop_en = 1'b1;
        single_frame(8'h5A, 8'h5A, 1'b1, 10, 38);
        single_frame(8'h81, 8'h81, 1'b1, 0, 0);

        // CLKS_PER_HALF_BIT = 1 instance
        rises = 0; dvs = 0; prev = 1'b0;
        tx1_byte = 8'h96; tx1_last = 1'b1; tx1_dv = 1'b1;
        tick();
        tx1_dv = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            if (sclk1 && !prev) begin
                chk("fast_rise_cycle", c, 4 + 2*rises);
                chk("fast_mosi_at_rise", mosi1, tx1_byte[7-rises]);
                rises++;
            end
            prev = sclk1;
            if (rx1_dv) dvs++;
            if (c == 1)  chk("fast_ss_low", ss1, 0);
            if (c == 19) begin
                chk("fast_rx_dv", rx1_dv, 1);
                chk("fast_rx_byte", rx1_byte, 8'h96);
                chk("fast_sclk_low", sclk1, 0);
            end
            if (c == 21) chk("fast_ss_high", ss1, 1);
            if (c < 21) tick();
        end
        chk("fast_rises", rises, 8);
        chk("fast_dv_count", dvs, 1);
        repeat (6) tick();

        // Reset asserted mid-SHIFT
        tx_byte = 8'hFF; tx_last = 1'b1; tx_dv = 1'b1;
        tick();
        tx_dv = 1'b0;
        repeat (9) tick();
        chk("pre_rst_ss_low", ss, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_ss", ss, 1);
        chk("midrst_sclk", sclk, 0);
        chk("midrst_txon", txon, 0);
        chk("midrst_ready", ready, 1);
        #2 rst_n = 1'b1;
        dvs = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (rx_dv) dvs++;
        end
        chk("midrst_no_rx_dv", dvs, 0);
        chk("midrst_ready_after", ready, 1);
        chk("midrst_ss_after", ss, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
